// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues single outstanding reads to instruction memory
// and buffers returned words with their addresses in a 2-entry FIFO for decode.
module instr_fetch #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          flush,
  input  logic [AW-1:0] pc_in,
  output logic          pc_inc,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [DW-1:0] ir_data,
  output logic [AW-1:0] ir_pc
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [1:0][AW-1:0]    addr_q, addr_d;
  logic [1:0][DW-1:0]    data_q, data_d;
  logic                  push;
  logic                  pop;

  // Request FSM: one read in flight; DROP waits out an ack that a flush orphaned.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    pc_inc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && !flush && (count_q < CW'(2))) begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_in;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (!flush) begin
            push   = 1'b1;
            pc_inc = 1'b1;
          end
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign pop = ir_valid && ir_ready;

  // FIFO with entry 0 as head; a push only ever lands at count 0 or 1.
  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          addr_d[count_q[0]] = mem_addr_q;
          data_d[count_q[0]] = mem_rdata;
          count_d            = count_q + CW'(1);
        end
        2'b01: begin
          addr_d[0] = addr_q[1];
          data_d[0] = data_q[1];
          count_d   = count_q - CW'(1);
        end
        2'b11: begin
          // Pop with push implies count was 1: new word becomes head.
          addr_d[0] = mem_addr_q;
          data_d[0] = mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ir_valid = (count_q != '0);
  assign ir_data  = data_q[0];
  assign ir_pc    = addr_q[0];

endmodule
